// File: rtl/tt_um_rr_arbiter_7_segment_pkg.sv
// tt_um_rr_arbiter_7_segment_pkg: shared FSM states and 7-segment codes
// Contents: state_t (IDLE/GRANT/COOL), SEG_TABLE (gfedcba per index 0..7), SEG_BLANK
package tt_um_rr_arbiter_7_segment_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_TABLE [8] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111
    };

    function automatic logic [6:0] seg_code(input logic [2:0] idx);
        return SEG_TABLE[idx];
    endfunction

endpackage

// File: rtl/tt_um_rr_arbiter_7_segment_rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority search over 8 requests
// Ports: req[7:0] requests, last[2:0] previous winner,
//        valid = any request set, index[2:0] = first set bit from last+1 upward (mod 8)
module rr_priority_pick (
    input  logic [7:0] req,
    input  logic [2:0] last,
    output logic       valid,
    output logic [2:0] index
);

    // Walk from the lowest priority (offset 8 == last) to the highest (offset 1)
    // so the final hit is the nearest requester after last.
    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        for (int i = 8; i >= 1; i--)
            if (req[last + 3'(i)]) begin
                valid = 1'b1;
                index = last + 3'(i);
            end
    end

endmodule

// File: rtl/tt_um_rr_arbiter_7_segment.sv
// tt_um_rr_arbiter_7_segment: 8-way round-robin arbiter with timeout and 7-segment grant display
// Ports: clk, rst_n (async active-low), req[7:0] requests, rel (grantee finished, sampled in GRANT),
//        gnt[7:0] one-hot grant, busy (in GRANT), timeout (1-cycle revoke pulse),
//        segments[6:0] gfedcba of granted index, none (high when no grant)
module tt_um_rr_arbiter_7_segment
    import tt_um_rr_arbiter_7_segment_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout,
    output logic [6:0] segments,
    output logic       none
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state;
    logic [2:0]      last;
    logic [2:0]      idx;
    logic [CW-1:0]   cnt;
    logic            valid;
    logic [2:0]      pick;
    logic            drop;
    logic            limit;

    rr_priority_pick u_pick (
        .req   (req),
        .last  (last),
        .valid (valid),
        .index (pick)
    );

    // A voluntary end (release or request withdrawn) wins over the limit,
    // so the timeout pulse only fires when the grant is truly revoked.
    assign drop  = rel || !req[idx];
    assign limit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 3'd7;
            idx      <= 3'd0;
            cnt      <= '0;
            gnt      <= 8'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            segments <= SEG_BLANK;
            none     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (valid) begin
                        state    <= GRANT;
                        gnt      <= 8'd1 << pick;
                        idx      <= pick;
                        last     <= pick;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        segments <= seg_code(pick);
                        none     <= 1'b0;
                    end
                end
                GRANT: begin
                    cnt <= cnt + 1'b1;
                    if (drop || limit) begin
                        state    <= COOL;
                        gnt      <= 8'd0;
                        busy     <= 1'b0;
                        segments <= SEG_BLANK;
                        none     <= 1'b1;
                        timeout  <= limit && !drop;
                    end
                end
                COOL: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_rr_arbiter_7_segment.sv
// tb_tt_um_rr_arbiter_7_segment: directed self-checking bench for the round-robin arbiter
module tb_tt_um_rr_arbiter_7_segment;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;
    logic [6:0] segments;
    logic       none;

    int n_chk = 0;
    int n_fail = 0;

    tt_um_rr_arbiter_7_segment #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rel      (rel),
        .gnt      (gnt),
        .busy     (busy),
        .timeout  (timeout),
        .segments (segments),
        .none     (none)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int i);
        case (i)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            default: return 7'b0000111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] eg, input logic eb, input logic et, input logic [6:0] es);
        logic [17:0] got;
        logic [17:0] exp;
        got = {gnt, busy, timeout, segments, none};
        exp = {eg, eb, et, es, (eg == 8'h00)};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got gnt=%h busy=%b timeout=%b seg=%b none=%b, expected gnt=%h busy=%b timeout=%b seg=%b none=%b",
                   tag, gnt, busy, timeout, segments, none, eg, eb, et, es, (eg == 8'h00));
        end
    endtask

    task automatic rel_cycle();
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        chk("cool", 8'h00, 1'b0, 1'b0, 7'b0000000);
        @(negedge clk);
        chk("idle_after_cool", 8'h00, 1'b0, 1'b0, 7'b0000000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset", 8'h00, 1'b0, 1'b0, 7'b0000000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_req", 8'h00, 1'b0, 1'b0, 7'b0000000);
        end
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_grant", 8'(1 << (k % 8)), 1'b1, 1'b0, seg(k % 8));
            if (k == 3) chk("seg_3", 8'h08, 1'b1, 1'b0, 7'b1001111);
            rel_cycle();
        end
        req = 8'h81;
        @(negedge clk);
        chk("wrap_to_7", 8'h80, 1'b1, 1'b0, 7'b0000111);
        rel_cycle();
        @(negedge clk);
        chk("wrap_to_0", 8'h01, 1'b1, 1'b0, 7'b0111111);
        rel_cycle();
        req = 8'h20;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("to_grant", 8'h20, 1'b1, 1'b0, 7'b1101101);
        end
        @(negedge clk);
        chk("to_pulse", 8'h00, 1'b0, 1'b1, 7'b0000000);
        @(negedge clk);
        chk("to_pulse_end", 8'h00, 1'b0, 1'b0, 7'b0000000);
        @(negedge clk);
        chk("to_regrant", 8'h20, 1'b1, 1'b0, 7'b1101101);
        repeat (3) begin
            @(negedge clk);
            chk("rel_grant", 8'h20, 1'b1, 1'b0, 7'b1101101);
        end
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        chk("rel_at_limit", 8'h00, 1'b0, 1'b0, 7'b0000000);
        @(negedge clk);
        chk("rel_idle", 8'h00, 1'b0, 1'b0, 7'b0000000);
        @(negedge clk);
        chk("drop_grant", 8'h20, 1'b1, 1'b0, 7'b1101101);
        req = 8'h04;
        @(negedge clk);
        chk("drop_cool", 8'h00, 1'b0, 1'b0, 7'b0000000);
        req = 8'h00;
        @(negedge clk);
        chk("drop_idle", 8'h00, 1'b0, 1'b0, 7'b0000000);
        req = 8'h20;
        @(negedge clk);
        chk("pre_reset", 8'h20, 1'b1, 1'b0, 7'b1101101);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 8'h00, 1'b0, 1'b0, 7'b0000000);
        @(negedge clk);
        chk("in_reset", 8'h00, 1'b0, 1'b0, 7'b0000000);
        rst_n = 1'b1;
        req = 8'h24;
        @(negedge clk);
        chk("post_reset", 8'h04, 1'b1, 1'b0, 7'b1011011);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
